// File: rtl/uart_sink_if.sv
// Byte stream from the UART receiver into the message sink.
// The receiver drives a one-cycle i_valid strobe, qualified by i_err.
interface uart_sink_if;
  logic [7:0] i_data;
  logic       i_valid;
  logic       i_err;

  modport master (output i_data, i_valid, i_err);
  modport slave  (input  i_data, i_valid, i_err);
endinterface

// File: rtl/uart_sink.sv
// Counts one MESSAGE_LEN-byte message from the UART receiver and folds it into
// a Fletcher-style {sum2, sum1} checksum, flagging receive errors and idle timeout.
module uart_sink #(
  parameter int MESSAGE_LEN = 512,
  parameter int TIMEOUT     = 65536,
  parameter int COUNT_BITS  = $clog2(MESSAGE_LEN+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_sink_if.slave            rx,
  output logic [15:0]           o_sum,
  output logic [COUNT_BITS-1:0] o_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_timeout
);

  localparam int                    IDLE_BITS = $clog2(TIMEOUT);
  localparam logic [COUNT_BITS-1:0] LAST_CNT  = COUNT_BITS'(MESSAGE_LEN-1);
  localparam logic [IDLE_BITS-1:0]  IDLE_LAST = IDLE_BITS'(TIMEOUT-1);

  typedef enum logic [1:0] {WAIT, RECV, DONE} state_t;

  state_t               state;
  logic [7:0]           sum1, sum2;
  logic [IDLE_BITS-1:0] idle;
  logic                 accept;
  logic [7:0]           sum1_nxt, sum2_nxt;

  assign accept   = rx.i_valid && !rx.i_err;
  assign sum1_nxt = sum1 + rx.i_data;
  assign sum2_nxt = sum2 + sum1_nxt;

  assign o_sum  = {sum2, sum1};
  assign o_busy = (state == RECV);
  assign o_done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WAIT;
      sum1      <= '0;
      sum2      <= '0;
      o_count   <= '0;
      idle      <= '0;
      o_error   <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          // First good byte starts a fresh message; sums begin from zero.
          if (accept) begin
            sum1      <= rx.i_data;
            sum2      <= rx.i_data;
            o_count   <= COUNT_BITS'(1);
            idle      <= '0;
            o_error   <= 1'b0;
            o_timeout <= 1'b0;
            state     <= (MESSAGE_LEN == 1) ? DONE : RECV;
          end
        end
        RECV: begin
          if (accept) begin
            sum1    <= sum1_nxt;
            sum2    <= sum2_nxt;
            o_count <= o_count + 1'b1;
            idle    <= '0;
            if (o_count == LAST_CNT) state <= DONE;
          end else begin
            // Errored bytes count as idle time; a byte landing on the
            // threshold cycle takes the accept branch and wins.
            if (rx.i_valid && rx.i_err) o_error <= 1'b1;
            if (idle == IDLE_LAST) begin
              o_timeout <= 1'b1;
              state     <= DONE;
            end else begin
              idle <= idle + 1'b1;
            end
          end
        end
        DONE:    state <= WAIT;
        default: state <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sink.sv
// Randomized scoreboard bench for uart_sink: a driver builds messages and queues
// expected results; a monitor pops and compares on every o_done pulse.
module tb_uart_sink;
  localparam int ML = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_sink_if bus ();
  uart_sink_if bus_d ();

  logic [15:0] o_sum;
  logic [2:0]  o_count;
  logic        o_busy, o_done, o_error, o_timeout;
  logic [15:0] d_sum;
  logic [9:0]  d_count;
  logic        d_busy, d_done, d_error, d_timeout;

  uart_sink #(.MESSAGE_LEN(ML), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rx(bus),
    .o_sum(o_sum), .o_count(o_count), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_timeout(o_timeout));

  uart_sink dut_d (
    .clk(clk), .rst(rst), .rx(bus_d),
    .o_sum(d_sum), .o_count(d_count), .o_busy(d_busy), .o_done(d_done),
    .o_error(d_error), .o_timeout(d_timeout));

  typedef struct {
    logic [15:0] sum;
    int          count;
    bit          err;
    bit          tmo;
    longint      done_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] msg_bytes[$];
  bit         msg_err;
  longint     cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         d_done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && d_done) d_done_cnt <= d_done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion must match the oldest queued expectation.
  exp_t e;
  always @(negedge clk) begin
    if (!rst && o_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {31'b0, o_done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sum",      {16'b0, o_sum},     {16'b0, e.sum});
        chk("count",    {29'b0, o_count},   e.count);
        chk("error",    {31'b0, o_error},   {31'b0, e.err});
        chk("timeout",  {31'b0, o_timeout}, {31'b0, e.tmo});
        chk("busy_off", {31'b0, o_busy},    32'd0);
        chk("done_cyc", cyc[31:0],          e.done_cyc[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit er, input logic [7:0] d);
    bus.i_valid = v;
    bus.i_err   = er;
    bus.i_data  = d;
    tick();
    bus.i_valid = 1'b0;
    bus.i_err   = 1'b0;
  endtask

  // Reference: Fletcher sums over the good bytes of the message.
  task automatic push_exp(input bit tmo);
    exp_t x;
    int s1 = 0, s2 = 0;
    foreach (msg_bytes[i]) begin
      s1 = (s1 + msg_bytes[i]) % 256;
      s2 = (s2 + s1) % 256;
    end
    x.sum      = 16'(s2 * 256 + s1);
    x.count    = msg_bytes.size();
    x.err      = msg_err;
    x.tmo      = tmo;
    x.done_cyc = cyc;
    exp_q.push_back(x);
    msg_bytes.delete();
    msg_err = 1'b0;
  endtask

  task automatic tk_good(input logic [7:0] d);
    drive(1'b1, 1'b0, d);
    msg_bytes.push_back(d);
    if (msg_bytes.size() == 1) begin
      chk("first_count", {29'b0, o_count},   32'd1);
      chk("first_error", {31'b0, o_error},   32'd0);
      chk("first_tmo",   {31'b0, o_timeout}, 32'd0);
      chk("first_busy",  {31'b0, o_busy},    32'd1);
      chk("first_sum",   {16'b0, o_sum},     {16'b0, d, d});
    end
    if (msg_bytes.size() == ML) push_exp(1'b0);
  endtask

  task automatic tk_err(input logic [7:0] d);
    drive(1'b1, 1'b1, d);
    if (msg_bytes.size() > 0) msg_err = 1'b1;
  endtask

  task automatic tk_idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  // Silence long enough to trip the idle timeout, optionally with one errored byte.
  task automatic tk_timeout();
    int pos = $urandom_range(0, TO);
    for (int k = 0; k < TO; k++) begin
      if (k == pos) tk_err(8'($urandom));
      else tk_idle(1);
    end
    push_exp(1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sum"},   {16'b0, o_sum},     32'd0);
    chk({tag, "_count"}, {29'b0, o_count},   32'd0);
    chk({tag, "_busy"},  {31'b0, o_busy},    32'd0);
    chk({tag, "_done"},  {31'b0, o_done},    32'd0);
    chk({tag, "_error"}, {31'b0, o_error},   32'd0);
    chk({tag, "_tmo"},   {31'b0, o_timeout}, 32'd0);
  endtask

  task automatic rand_msg();
    bit tmo = ($urandom % 4) == 0;
    int n   = tmo ? $urandom_range(1, ML-1) : ML;
    if ($urandom % 3 == 0) tk_err(8'($urandom));
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        if ($urandom % 6 == 0) tk_idle(TO-1);
        else begin
          repeat ($urandom % 3) tk_err(8'($urandom));
          tk_idle($urandom % 7);
        end
      end
      tk_good(8'($urandom));
    end
    if (tmo) tk_timeout();
    // DONE cycle: anything offered here is dropped.
    if ($urandom % 2) drive(1'b1, 1'($urandom), 8'($urandom));
    else tk_idle(1);
    tk_idle($urandom % 3);
  endtask

  initial begin
    bus.i_valid = 0; bus.i_err = 0; bus.i_data = 0;
    bus_d.i_valid = 0; bus_d.i_err = 0; bus_d.i_data = 0;
    msg_err = 0;
    tick(); tick();
    chk_all_zero("reset");
    chk("d_reset_sum",   {16'b0, d_sum},   32'd0);
    chk("d_reset_count", {22'b0, d_count}, 32'd0);
    rst = 1'b0;
    tick();

    // 01..04 with gaps
    tk_good(8'h01); tk_idle(2); tk_good(8'h02); tk_idle(1);
    tk_good(8'h03); tk_idle(3); tk_good(8'h04);
    chk("tp1_sum", {16'b0, o_sum}, 32'h140A);
    tk_idle(2);

    // 05,06 then silence
    tk_good(8'h05); tk_good(8'h06);
    tk_idle(TO);
    push_exp(1'b1);
    chk("tp3_sum", {16'b0, o_sum}, 32'h100B);
    tk_idle(2);

    // errored byte inside a message, extra byte after completion lands in DONE
    tk_good(8'h01); tk_err(8'h02); tk_good(8'h03); tk_good(8'h04); tk_good(8'h05);
    drive(1'b1, 1'b0, 8'hAA);
    tk_good(8'h11);
    tk_good(8'h22); tk_good(8'h33); tk_good(8'h44);
    tk_idle(1);

    repeat (40) rand_msg();

    // async reset mid-message discards the partial result
    tk_good(8'h5A); tk_good(8'hA5);
    #1 rst = 1'b1;
    #1 chk_all_zero("midrst");
    msg_bytes.delete();
    msg_err = 1'b0;
    tick();
    rst = 1'b0;
    tk_good(8'h10); tk_idle(1); tk_good(8'h20); tk_good(8'h30); tk_good(8'h40);
    tk_idle(3);

    // default-size instance: 512 bytes of 0x01
    for (int i = 0; i < 512; i++) begin
      bus_d.i_valid = 1'b1;
      bus_d.i_data  = 8'h01;
      tick();
      bus_d.i_valid = 1'b0;
      if (i < 511 && (i % 50) == 0) chk("d_busy", {31'b0, d_busy}, 32'd1);
      if (i < 511) repeat ($urandom % 3) tick();
    end
    chk("d_done",    {31'b0, d_done},    32'd1);
    chk("d_sum",     {16'b0, d_sum},     32'd0);
    chk("d_count",   {22'b0, d_count},   32'd512);
    chk("d_busy_off",{31'b0, d_busy},    32'd0);
    chk("d_error",   {31'b0, d_error},   32'd0);
    chk("d_tmo",     {31'b0, d_timeout}, 32'd0);
    tick(); tick(); tick();
    chk("d_done_cnt", d_done_cnt, 32'd1);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
